// File: rtl/adda_pkg.sv
// Shared definitions for the ADC capture buffer slice: parameter defaults
// and the controller state encoding.
package adda_pkg;

    localparam int unsigned DATA_W_DEF = 8;    // ADC sample width
    localparam int unsigned DEPTH_DEF  = 256;  // samples per capture (power of two, >= 4)

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_e;

endpackage

// File: rtl/adda_sdp_ram.sv
// Simple dual-port sample store: one write port, one read port with a
// registered output (1-cycle read latency). No reset on the array or the
// read register so it maps onto block RAM.
//
// Ports:
//   clk_i    - clock, rising edge
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   re_i     - read enable; rdata_o holds its value while re_i is low
//   raddr_i  - read address
//   rdata_o  - registered read data
module adda_sdp_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned WORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered ADC capture buffer. Generates the ADC sample clock (i_clk/2),
// waits for a level crossing on the strobed samples, captures DEPTH samples
// starting with the triggering one, then streams them out over valid/ready.
//
// Ports:
//   i_clk, i_rst_n           - system clock; asynchronous active-low reset
//   o_adc_clk                - registered ADC sample clock
//   i_adc_data               - ADC parallel data
//   i_arm / i_abort          - start a capture / return to IDLE (abort wins)
//   i_trig_level             - unsigned trigger threshold
//   i_trig_falling           - 0 = rising crossing, 1 = falling crossing
//   o_rd_valid, i_rd_ready   - readout handshake
//   o_rd_data, o_rd_last     - readout sample, marks index DEPTH-1
//   o_busy                   - high outside IDLE
//   o_done                   - one-cycle pulse after the last sample is accepted
module adc_capture_buffer
    import adda_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_adc_clk,
    input  logic [DATA_W-1:0] i_adc_data,
    input  logic              i_arm,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_trig_level,
    input  logic              i_trig_falling,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    state_e            state_q,    state_d;
    logic              adc_clk_q;
    logic [DATA_W-1:0] prev_q,     prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic [AW-1:0]     wptr_q,     wptr_d;
    logic [AW-1:0]     rptr_q,     rptr_d;
    logic              rd_end_q,   rd_end_d;   // read of DEPTH-1 already issued
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q,  rd_last_d;
    logic              done_q,     done_d;

    logic              strobe;
    logic              trig_hit;
    logic              fire;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    // The sample strobe is the high phase of the ADC clock.
    assign strobe = adc_clk_q;
    assign fire   = rd_valid_q & i_rd_ready;

    always_comb begin
        if (i_trig_falling) begin
            trig_hit = (prev_q > i_trig_level) && (i_adc_data <= i_trig_level);
        end else begin
            trig_hit = (prev_q < i_trig_level) && (i_adc_data >= i_trig_level);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            adc_clk_q  <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_end_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            adc_clk_q  <= ~adc_clk_q;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_end_q   <= rd_end_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_end_d   = rd_end_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        done_d     = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = wptr_q;
        ram_re     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                prev_vld_d = 1'b0;
                if (i_arm) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (strobe) begin
                    prev_d     = i_adc_data;
                    prev_vld_d = 1'b1;
                    // The first strobe after arming only seeds prev.
                    if (prev_vld_q && trig_hit) begin
                        ram_we    = 1'b1;
                        ram_waddr = '0;
                        wptr_d    = AW'(1);
                        state_d   = ST_CAPTURE;
                    end
                end
            end

            ST_CAPTURE: begin
                if (strobe) begin
                    ram_we = 1'b1;
                    if (wptr_q == PTR_LAST) begin
                        wptr_d   = '0;
                        rptr_d   = '0;
                        rd_end_d = 1'b0;
                        state_d  = ST_READOUT;
                    end else begin
                        wptr_d = wptr_q + AW'(1);
                    end
                end
            end

            ST_READOUT: begin
                // The RAM output register doubles as the output stage: a new
                // read is issued only when the current word is empty or leaving,
                // so the word under a stall stays put.
                if (fire && rd_last_q) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    rptr_d     = '0;
                    rd_end_d   = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else if ((!rd_valid_q || fire) && !rd_end_q) begin
                    ram_re     = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (rptr_q == PTR_LAST);
                    if (rptr_q == PTR_LAST) begin
                        rd_end_d = 1'b1;
                    end else begin
                        rptr_d = rptr_q + AW'(1);
                    end
                end else if (fire) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (i_abort) begin
            state_d    = ST_IDLE;
            prev_vld_d = 1'b0;
            wptr_d     = '0;
            rptr_d     = '0;
            rd_end_d   = 1'b0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            done_d     = 1'b0;
            ram_we     = 1'b0;
            ram_re     = 1'b0;
        end
    end

    adda_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (AW)
    ) u_ram (
        .clk_i   (i_clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (i_adc_data),
        .re_i    (ram_re),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    assign o_adc_clk  = adc_clk_q;
    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_valid_q ? ram_rdata : '0;
    assign o_rd_last  = rd_last_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
module tb_adc_capture_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          adc_clk;
    logic [DW-1:0] adc_data = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] trig_level = 8'h80;
    logic          trig_falling = 1'b0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    // ADC source: 0 = ramp, 1 = constant, 2 = 0xF0/0x10 square.
    int            mode = 0;
    logic [DW-1:0] const_val = 8'h90;

    logic [DW-1:0] got[$];
    logic          got_last[$];
    int            stall_err;
    int            done_seen;
    int            drain_cyc;
    logic          post_done, post_valid, post_busy;

    adc_capture_buffer #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .o_adc_clk      (adc_clk),
        .i_adc_data     (adc_data),
        .i_arm          (arm),
        .i_abort        (abort),
        .i_trig_level   (trig_level),
        .i_trig_falling (trig_falling),
        .o_rd_valid     (rd_valid),
        .i_rd_ready     (rd_ready),
        .o_rd_data      (rd_data),
        .o_rd_last      (rd_last),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    // New ADC value once per sample period, stable across the strobe edge.
    always @(negedge clk) begin
        if (!adc_clk) begin
            case (mode)
                0:       adc_data = adc_data + 8'd1;
                1:       adc_data = const_val;
                default: adc_data = (adc_data == 8'hF0) ? 8'h10 : 8'hF0;
            endcase
        end
    end

    task automatic pulse(input logic a, input logic b);
        @(negedge clk);
        arm   = a;
        abort = b;
        @(negedge clk);
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_data(input logic [DW-1:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1200 && !ok; i++) begin
            @(negedge clk);
            if (adc_data == v) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2500 && !ok; i++) begin
            @(negedge clk);
            if (rd_valid) ok = 1'b1;
        end
    endtask

    // Collects the readout stream; the calling test judges the results.
    task automatic drain(input bit rnd, output bit ok);
        bit            held;
        bit            fin;
        logic [DW-1:0] hd;
        logic          hl;
        int            cyc;
        got.delete();
        got_last.delete();
        stall_err = 0;
        done_seen = 0;
        held = 1'b0;
        fin  = 1'b0;
        hd   = '0;
        hl   = 1'b0;
        for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (held && (!rd_valid || rd_data !== hd || rd_last !== hl)) stall_err++;
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = rd_valid && !rd_ready;
            hd   = rd_data;
            hl   = rd_last;
            if (rd_valid && rd_ready) begin
                got.push_back(rd_data);
                got_last.push_back(rd_last);
                if (rd_last) fin = 1'b1;
            end
        end
        drain_cyc = cyc;
        @(negedge clk);
        rd_ready   = 1'b0;
        post_done  = done;
        post_valid = rd_valid;
        post_busy  = busy;
        @(negedge clk);
        if (done) done_seen++;
        ok = fin;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (adc_clk !== 1'b0) begin n_err++; $display("FAIL reset_adc_clk got=%b exp=0", adc_clk); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", rd_data); end
        n_cmp++; if (rd_last !== 1'b0) begin n_err++; $display("FAIL reset_last got=%b exp=0", rd_last); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        rst_n = 1'b1;
    endtask

    task automatic test_adc_clk;
        logic c1, c2, c3;
        @(negedge clk); c1 = adc_clk;
        @(negedge clk); c2 = adc_clk;
        @(negedge clk); c3 = adc_clk;
        n_cmp++; if ({c1, c2, c3} !== 3'b101) begin n_err++; $display("FAIL adc_clk_toggle got=%b exp=101", {c1, c2, c3}); end
    endtask

    task automatic test_ramp_rising;
        bit ok;
        int bad, lbad;
        mode = 0; trig_falling = 1'b0; trig_level = 8'h80;
        wait_data(8'h10, ok);
        pulse(1'b1, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ramp_busy_armed got=%b exp=1", busy); end
        wait_valid(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ramp_valid_timeout got=%b exp=1", ok); end
        drain(1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ramp_last_timeout got=%b exp=1", ok); end
        n_cmp++; if (got.size() !== DEPTH) begin n_err++; $display("FAIL ramp_count got=%0d exp=%0d", got.size(), DEPTH); end
        n_cmp++; if (got.size() == 0 || got[0] !== 8'h80) begin n_err++; $display("FAIL ramp_first got=%h exp=80", (got.size() > 0) ? got[0] : 8'hxx); end
        bad = 0; lbad = 0;
        foreach (got[k]) begin
            if (got[k] !== 8'(8'h80 + k)) bad++;
            if (got_last[k] !== (k == DEPTH - 1)) lbad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL ramp_order got=%0d_bad exp=0", bad); end
        n_cmp++; if (lbad !== 0) begin n_err++; $display("FAIL ramp_last_flag got=%0d_bad exp=0", lbad); end
        n_cmp++; if (drain_cyc !== DEPTH) begin n_err++; $display("FAIL ramp_throughput got=%0d_cycles exp=%0d", drain_cyc, DEPTH); end
        n_cmp++; if (post_done !== 1'b1) begin n_err++; $display("FAIL ramp_done_pulse got=%b exp=1", post_done); end
        n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL ramp_done_extra got=%0d exp=0", done_seen); end
        n_cmp++; if (post_valid !== 1'b0) begin n_err++; $display("FAIL ramp_valid_drop got=%b exp=0", post_valid); end
        n_cmp++; if (post_busy !== 1'b0) begin n_err++; $display("FAIL ramp_idle got=%b exp=0", post_busy); end
    endtask

    task automatic test_constant;
        int vseen;
        mode = 1; const_val = 8'h90; trig_falling = 1'b0; trig_level = 8'h80;
        repeat (4) @(negedge clk);
        pulse(1'b1, 1'b0);
        vseen = 0;
        repeat (1500) begin
            @(negedge clk);
            if (rd_valid || done) vseen++;
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL const_busy got=%b exp=1", busy); end
        n_cmp++; if (vseen !== 0) begin n_err++; $display("FAIL const_no_trigger got=%0d exp=0", vseen); end
        pulse(1'b0, 1'b1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL const_abort got=%b exp=0", busy); end
    endtask

    task automatic test_falling;
        bit ok;
        int bad;
        mode = 2; trig_falling = 1'b1; trig_level = 8'h80;
        repeat (4) @(negedge clk);
        pulse(1'b1, 1'b0);
        wait_valid(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL fall_valid_timeout got=%b exp=1", ok); end
        drain(1'b0, ok);
        n_cmp++; if (got.size() !== DEPTH) begin n_err++; $display("FAIL fall_count got=%0d exp=%0d", got.size(), DEPTH); end
        n_cmp++; if (got.size() == 0 || got[0] !== 8'h10) begin n_err++; $display("FAIL fall_first got=%h exp=10", (got.size() > 0) ? got[0] : 8'hxx); end
        bad = 0;
        foreach (got[k]) if (got[k] !== ((k % 2 == 0) ? 8'h10 : 8'hF0)) bad++;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL fall_pattern got=%0d_bad exp=0", bad); end
        n_cmp++; if (post_done !== 1'b1) begin n_err++; $display("FAIL fall_done got=%b exp=1", post_done); end
        trig_falling = 1'b0;
    endtask

    task automatic test_random_ready;
        bit ok;
        int bad;
        mode = 0; trig_falling = 1'b0; trig_level = 8'h80;
        wait_data(8'h10, ok);
        pulse(1'b1, 1'b0);
        wait_valid(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rnd_valid_timeout got=%b exp=1", ok); end
        drain(1'b1, ok);
        n_cmp++; if (got.size() !== DEPTH) begin n_err++; $display("FAIL rnd_count got=%0d exp=%0d", got.size(), DEPTH); end
        bad = 0;
        foreach (got[k]) if (got[k] !== 8'(8'h80 + k)) bad++;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rnd_order got=%0d_bad exp=0", bad); end
        n_cmp++; if (stall_err !== 0) begin n_err++; $display("FAIL rnd_stall_stable got=%0d exp=0", stall_err); end
        n_cmp++; if (post_done !== 1'b1 || done_seen !== 0) begin n_err++; $display("FAIL rnd_done got=%b/%0d exp=1/0", post_done, done_seen); end
    endtask

    task automatic test_abort;
        bit ok;
        int vseen;
        mode = 0; trig_falling = 1'b0; trig_level = 8'h80;
        wait_data(8'h10, ok);
        pulse(1'b1, 1'b0);
        wait_data(8'hE4, ok);   // ~sample 100 of the capture
        n_cmp++; if (ok !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL abort_in_capture got=%b/%b exp=1/1", ok, busy); end
        pulse(1'b0, 1'b1);
        n_cmp++; if (busy !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL abort_idle got=%b%b%b exp=000", busy, rd_valid, done); end
        vseen = 0;
        repeat (700) begin
            @(negedge clk);
            if (rd_valid || done || busy) vseen++;
        end
        n_cmp++; if (vseen !== 0) begin n_err++; $display("FAIL abort_quiet got=%0d exp=0", vseen); end
        pulse(1'b1, 1'b1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arm_abort_idle got=%b exp=0", busy); end
        pulse(1'b1, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rearm got=%b exp=1", busy); end
        pulse(1'b1, 1'b1);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL arm_abort_armed got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_reset_mid_readout;
        bit ok;
        int bad;
        mode = 0; trig_falling = 1'b0; trig_level = 8'h80;
        wait_data(8'h10, ok);
        pulse(1'b1, 1'b0);
        wait_valid(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rst_valid_timeout got=%b exp=1", ok); end
        rd_ready = 1'b1;
        repeat (10) @(negedge clk);
        rd_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({adc_clk, rd_valid, rd_last, busy, done} !== 5'b0 || rd_data !== 8'h00) begin
            n_err++; $display("FAIL async_reset got=%b%b%b%b%b/%h exp=00000/00", adc_clk, rd_valid, rd_last, busy, done, rd_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_data(8'h10, ok);
        pulse(1'b1, 1'b0);
        wait_valid(ok);
        drain(1'b0, ok);
        n_cmp++; if (got.size() !== DEPTH) begin n_err++; $display("FAIL rst_recapture_count got=%0d exp=%0d", got.size(), DEPTH); end
        bad = 0;
        foreach (got[k]) if (got[k] !== 8'(8'h80 + k)) bad++;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rst_recapture_order got=%0d_bad exp=0", bad); end
        n_cmp++; if (post_done !== 1'b1) begin n_err++; $display("FAIL rst_recapture_done got=%b exp=1", post_done); end
    endtask

    initial begin
        test_reset();
        test_adc_clk();
        test_ramp_rising();
        test_constant();
        test_falling();
        test_random_ready();
        test_abort();
        test_reset_mid_readout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_capture_buffer.md
ADC_CAPTURE_BUFFER -- requirements
Module: adc_capture_buffer

Interface
REQ-001 Parameter DATA_W, default 8, ADC sample width in bits.
REQ-002 Parameter DEPTH, default 256, samples per capture; SHALL be a power of two, at least 4.
REQ-003 i_clk  input  1  single system clock (25 MHz board clock); all logic on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 o_adc_clk  output  1  registered ADC sample clock, i_clk/2.
REQ-006 i_adc_data  input  DATA_W  parallel ADC output bus.
REQ-007 i_arm  input  1  one-cycle request to start a capture.
REQ-008 i_abort  input  1  one-cycle request to return to IDLE.
REQ-009 i_trig_level  input  DATA_W  unsigned trigger threshold.
REQ-010 i_trig_falling  input  1  trigger polarity: 0 = rising crossing, 1 = falling crossing.
REQ-011 o_rd_valid  output  1  readout sample valid.
REQ-012 i_rd_ready  input  1  readout consumer ready.
REQ-013 o_rd_data  output  DATA_W  readout sample.
REQ-014 o_rd_last  output  1  marks sample index DEPTH-1.
REQ-015 o_busy  output  1  high in any state except IDLE.
REQ-016 o_done  output  1  one-cycle pulse after the last sample is accepted.

Function
REQ-017 o_adc_clk SHALL toggle every i_clk cycle; sample strobe SHALL assert on cycles where o_adc_clk is 1, registering i_adc_data (one strobe per two cycles).
REQ-018 States SHALL be IDLE, ARMED, CAPTURE, READOUT.
REQ-019 IDLE -> ARMED on i_arm; i_arm in any other state SHALL be ignored.
REQ-020 ARMED: the block SHALL keep the previous strobed sample; a rising trigger fires when prev < i_trig_level and cur >= i_trig_level; a falling trigger fires when prev > i_trig_level and cur <= i_trig_level.
REQ-021 The first strobe after entering ARMED SHALL only load prev and SHALL NOT fire a trigger.
REQ-022 On trigger: the triggering sample SHALL be written at address 0, and the state SHALL go to CAPTURE.
REQ-023 CAPTURE: each strobe SHALL write the next address; after address DEPTH-1 is written, the state SHALL go to READOUT with the read pointer at 0 and no further writes.
REQ-024 READOUT SHALL use a valid/ready stream: a transfer occurs when o_rd_valid and i_rd_ready are both high.
REQ-025 o_rd_valid SHALL first assert no more than 2 cycles after entering READOUT.
REQ-026 While o_rd_valid=1 and i_rd_ready=0, o_rd_data and o_rd_last SHALL hold stable.
REQ-027 With i_rd_ready held high, readout SHALL sustain one sample per cycle.
REQ-028 Samples SHALL emerge in address order 0..DEPTH-1.
REQ-029 On the transfer with o_rd_last=1, the block SHALL go to IDLE, o_done SHALL pulse the following cycle, and o_rd_valid SHALL drop.
REQ-030 i_abort in any state SHALL go to IDLE next cycle with o_rd_valid=0, o_done=0, and the pointers cleared.
REQ-031 i_abort SHALL win over i_arm on the same cycle.
REQ-032 Pointers SHALL be log2(DEPTH) bits; only the terminal comparisons at DEPTH-1 end a phase, and there SHALL be no wrap-around.

Reset
REQ-033 While i_rst_n=0: state=IDLE, o_adc_clk=0, o_rd_valid=0, o_rd_data=0, o_rd_last=0, o_busy=0, o_done=0, pointers and prev=0; the buffer contents are undefined.
REQ-034 Reset assertion mid-capture or mid-readout SHALL take effect immediately (asynchronous); deassertion SHALL be used only after synchronisation in the parent.

Structure
REQ-035 The state encoding and the DATA_W/DEPTH defaults SHALL live in a shared package adda_pkg.
REQ-036 The sample store SHALL be one sub-module, adda_sdp_ram: simple dual-port, registered read, 1-cycle read latency, inferable as block RAM.

Verification
REQ-037 Ramp 0..255 on i_adc_data, level 0x80, rising, arm -> first readout sample 0x80, then DEPTH consecutive samples, o_rd_last on the 256th, o_done pulses once.
REQ-038 Input constant 0x90, level 0x80, arm -> stays ARMED, no trigger, o_busy=1 indefinitely.
REQ-039 Falling trigger, square wave 0xF0/0x10, level 0x80 -> first sample 0x10 or below level, capture completes.
REQ-040 Readout with i_rd_ready random 50% -> no sample lost or duplicated; o_rd_data is stable while stalled.
REQ-041 i_abort in CAPTURE at sample 100, and i_arm+i_abort on the same cycle -> IDLE next cycle, o_busy=0, no o_done.
REQ-042 i_rst_n pulsed low mid-READOUT -> all outputs at reset values asynchronously; a subsequent arm captures normally.
